// File: rtl/conway_vga_render.sv
// conway_vga_render: VGA scan-out of the Life grid with an edit-mode brush overlay.
// State, cursor and brush are snapshotted at vblank so a frame never tears.
module conway_vga_render #(
  parameter int GRID_X  = 64,
  parameter int GRID_Y  = 48,
  parameter int CELL_PX = 10,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pix_ce,
  input  logic [GRID_X*GRID_Y-1:0]   state,
  input  logic                       draw,
  input  logic [7:0]                 cursor_x,
  input  logic [7:0]                 cursor_y,
  input  logic [63:0]                pattern_mat,
  output logic                       hsync,
  output logic                       vsync,
  output logic [11:0]                rgb,
  output logic                       frame_tick
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int NC    = GRID_X * GRID_Y;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int SW    = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam int IW    = $clog2(NC);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VL   = HW'(H_VIS);
  localparam logic [HW-1:0] HS_BEG = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [HW-1:0] GX_H   = HW'(GRID_X);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VL   = VW'(V_VIS);
  localparam logic [VW-1:0] VS_BEG = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [VW-1:0] GY_V   = VW'(GRID_Y);
  localparam logic [SW-1:0] S_LAST = SW'(CELL_PX - 1);

  logic [HW-1:0] h_q, h_d, cx_q, cx_d;
  logic [VW-1:0] v_q, v_d, cy_q, cy_d;
  logic [SW-1:0] sx_q, sx_d, sy_q, sy_d;

  logic [NC-1:0] state_q;
  logic          draw_q;
  logic [7:0]    curx_q, cury_q;
  logic [63:0]   pat_q;

  logic          hs_q, vs_q, ft_q;
  logic [11:0]   rgb_q;

  logic h_wrap, v_wrap, snap;

  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);
  assign snap   = pix_ce && (h_q == '0) && (v_q == V_VL);

  // Sub-cell counters replace a divide-by-CELL_PX on the raster position.
  always_comb begin
    h_d  = h_q;
    v_d  = v_q;
    cx_d = cx_q;
    cy_d = cy_q;
    sx_d = sx_q;
    sy_d = sy_q;
    if (pix_ce) begin
      h_d = h_wrap ? '0 : h_q + 1'b1;
      if (h_wrap) begin
        sx_d = '0;
        cx_d = '0;
      end else if (sx_q == S_LAST) begin
        sx_d = '0;
        cx_d = cx_q + 1'b1;
      end else begin
        sx_d = sx_q + 1'b1;
      end
      if (h_wrap) begin
        v_d = v_wrap ? '0 : v_q + 1'b1;
        if (v_wrap) begin
          sy_d = '0;
          cy_d = '0;
        end else if (sy_q == S_LAST) begin
          sy_d = '0;
          cy_d = cy_q + 1'b1;
        end else begin
          sy_d = sy_q + 1'b1;
        end
      end
    end
  end

  logic          vis, in_grid, alive, cur_ok, in_win, pbit, ovl;
  logic [7:0]    cx8, cy8;
  logic [8:0]    ox, oy;
  logic [IW-1:0] idx;
  logic          hs_d, vs_d;
  logic [11:0]   rgb_d;

  assign vis     = (h_q < H_VL) && (v_q < V_VL);
  assign in_grid = (cx_q < GX_H) && (cy_q < GY_V);
  assign idx     = IW'(cy_q) * IW'(GRID_X) + IW'(cx_q);
  assign alive   = in_grid && state_q[idx];
  assign cx8     = 8'(cx_q);
  assign cy8     = 8'(cy_q);

  // Offsets from the brush origin, wrapped modulo the grid size.
  assign ox = (cx8 >= curx_q) ? {1'b0, cx8 - curx_q}
            : {1'b0, cx8} + 9'(GRID_X) - {1'b0, curx_q};
  assign oy = (cy8 >= cury_q) ? {1'b0, cy8 - cury_q}
            : {1'b0, cy8} + 9'(GRID_Y) - {1'b0, cury_q};

  assign cur_ok = ({1'b0, curx_q} < 9'(GRID_X))
               && ({1'b0, cury_q} < 9'(GRID_Y));
  assign in_win = (ox < 9'd8) && (oy < 9'd8);
  assign pbit   = pat_q[{oy[2:0], ox[2:0]}];
  assign ovl    = !draw_q && cur_ok && in_win;

  assign hs_d = !((h_q >= HS_BEG) && (h_q < HS_END));
  assign vs_d = !((v_q >= VS_BEG) && (v_q < VS_END));

  always_comb begin
    rgb_d = 12'h000;
    if (!vis) begin
      rgb_d = 12'h000;
    end else if (!in_grid) begin
      rgb_d = 12'h111;
    end else if (ovl) begin
      if (pbit) rgb_d = alive ? 12'hFF0 : 12'h0F0;
      else      rgb_d = alive ? 12'hFFF : 12'h004;
    end else begin
      rgb_d = alive ? 12'hFFF : 12'h000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q     <= '0;
      v_q     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      state_q <= '0;
      draw_q  <= 1'b0;
      curx_q  <= '0;
      cury_q  <= '0;
      pat_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      rgb_q   <= '0;
      ft_q    <= 1'b0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      ft_q <= snap;
      if (pix_ce) begin
        hs_q  <= hs_d;
        vs_q  <= vs_d;
        rgb_q <= rgb_d;
      end
      if (snap) begin
        state_q <= state;
        draw_q  <= draw;
        curx_q  <= cursor_x;
        cury_q  <= cursor_y;
        pat_q   <= pattern_mat;
      end
    end
  end

  assign hsync      = hs_q;
  assign vsync      = vs_q;
  assign rgb        = rgb_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_conway_vga_render.sv
// Bench for conway_vga_render: pixel model + scoreboard, spot-check table.
// Timing is scaled down (cells 2 px) so several whole frames fit a short run.
module tb_conway_vga_render;

  localparam int GX = 64, GY = 48, CP = 2;
  localparam int HV = 136, HF = 2, HS = 4, HB = 2;
  localparam int VV = 98,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic             clk = 1'b0;
  logic             rst, pix_ce, draw;
  logic [GX*GY-1:0] state;
  logic [7:0]       cursor_x, cursor_y;
  logic [63:0]      pattern_mat;
  logic             hsync, vsync, frame_tick;
  logic [11:0]      rgb;

  conway_vga_render #(
    .GRID_X(GX), .GRID_Y(GY), .CELL_PX(CP),
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .state(state), .draw(draw),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .pattern_mat(pattern_mat),
    .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] px;
    logic        ft;
    int          h, v, fr;
  } exp_t;

  typedef struct {
    int          fr, h, v;
    logic [11:0] rgb;
  } probe_t;

  exp_t   sb[$];
  probe_t pt[$];

  int n_tot = 0, n_pass = 0, n_fail = 0;
  int m_h = 0, m_v = 0, frame = 0;
  int hs_low = 0, vs_low = 0, ft_cnt = 0, hits = 0;
  logic [13:0] last_px = '0;

  logic [GX*GY-1:0] sh_state;
  logic             sh_draw;
  logic [7:0]       sh_cx, sh_cy;
  logic [63:0]      sh_pat;

  task automatic chk(input string nm, input logic ok,
                     input logic [31:0] act, input logic [31:0] want);
    n_tot++;
    if (ok) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic logic [13:0] model_pix(input int h, input int v);
    logic hs, vs, al, pb;
    logic [11:0] c;
    int cx, cy, ox, oy;
    hs = !(h >= HV + HF && h < HV + HF + HS);
    vs = !(v >= VV + VF && v < VV + VF + VS);
    cx = h / CP;
    cy = v / CP;
    if (h >= HV || v >= VV) c = 12'h000;
    else if (cx >= GX || cy >= GY) c = 12'h111;
    else begin
      al = sh_state[cy * GX + cx];
      c  = al ? 12'hFFF : 12'h000;
      if (!sh_draw && sh_cx < GX && sh_cy < GY) begin
        ox = (cx - int'(sh_cx) + GX) % GX;
        oy = (cy - int'(sh_cy) + GY) % GY;
        if (ox < 8 && oy < 8) begin
          pb = sh_pat[oy * 8 + ox];
          if (pb) c = al ? 12'hFF0 : 12'h0F0;
          else    c = al ? 12'hFFF : 12'h004;
        end
      end
    end
    return {hs, vs, c};
  endfunction

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      m_h = 0; m_v = 0;
      sh_state = '0; sh_draw = 1'b0;
      sh_cx = '0; sh_cy = '0; sh_pat = '0;
    end else if (pix_ce) begin
      e.px = model_pix(m_h, m_v);
      e.ft = (m_h == 0 && m_v == VV);
      e.h = m_h; e.v = m_v; e.fr = frame;
      sb.push_back(e);
      if (e.ft) begin
        sh_state = state; sh_draw = draw;
        sh_cx = cursor_x; sh_cy = cursor_y; sh_pat = pattern_mat;
      end
      if (m_h == HT - 1) begin
        m_h = 0;
        if (m_v == VT - 1) begin m_v = 0; frame++; end
        else m_v++;
      end else m_h++;
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      last_px = e.px;
      chk($sformatf("pix f%0d h%0d v%0d", e.fr, e.h, e.v),
          {hsync, vsync, rgb} == e.px,
          32'({hsync, vsync, rgb}), 32'(e.px));
      chk($sformatf("frame_tick f%0d h%0d v%0d", e.fr, e.h, e.v),
          frame_tick == e.ft, 32'(frame_tick), 32'(e.ft));
      if (e.fr == 0) begin
        if (!hsync) hs_low++;
        if (!vsync) vs_low++;
      end
      if (e.fr <= 3 && frame_tick) ft_cnt++;
      foreach (pt[i]) begin
        if (pt[i].fr == e.fr && pt[i].h == e.h && pt[i].v == e.v) begin
          hits++;
          chk($sformatf("probe f%0d h%0d v%0d", e.fr, e.h, e.v),
              rgb == pt[i].rgb, 32'(rgb), 32'(pt[i].rgb));
        end
      end
    end
  endtask

  task automatic run_until(input int fr, input int v, input int h);
    int guard;
    guard = 0;
    while (!(frame == fr && m_v == v && m_h == h) && guard < 90000) begin
      tick();
      guard++;
    end
    if (guard >= 90000) begin
      $display("FAIL run_until: position f%0d v%0d h%0d not reached", fr, v, h);
      $fatal(1);
    end
  endtask

  function automatic probe_t pr(input int fr, input int h, input int v,
                                input logic [11:0] c);
    probe_t p;
    p.fr = fr; p.h = h; p.v = v; p.rgb = c;
    return p;
  endfunction

  initial begin
    pt.push_back(pr(0,   0,  0, 12'h004));
    pt.push_back(pr(0,  16,  0, 12'h000));
    pt.push_back(pr(1,   6, 10, 12'hFFF));
    pt.push_back(pr(1,   7, 11, 12'hFFF));
    pt.push_back(pr(1,   5, 10, 12'h000));
    pt.push_back(pr(1,   8, 10, 12'h000));
    pt.push_back(pr(1,   6,  9, 12'h000));
    pt.push_back(pr(1,   6, 12, 12'h000));
    pt.push_back(pr(1, 128,  0, 12'h111));
    pt.push_back(pr(1,   0, 96, 12'h111));
    pt.push_back(pr(1, 136,  0, 12'h000));
    pt.push_back(pr(1,   0, 98, 12'h000));
    pt.push_back(pr(2, 124, 94, 12'h0F0));
    pt.push_back(pr(2, 126, 94, 12'h004));
    pt.push_back(pr(2,   0,  0, 12'h004));
    pt.push_back(pr(2, 126,  0, 12'h0F0));
    pt.push_back(pr(2,  20, 20, 12'h000));
    pt.push_back(pr(2, 130, 94, 12'h111));
    pt.push_back(pr(3, 124, 94, 12'hFF0));
    pt.push_back(pr(3,   0,  0, 12'hFFF));
    pt.push_back(pr(3, 126,  0, 12'h0F0));
    pt.push_back(pr(100, 0,  0, 12'h004));

    rst = 1'b1; pix_ce = 1'b1;
    state = '0; state[5*GX+3] = 1'b1;
    draw = 1'b1; cursor_x = 8'd0; cursor_y = 8'd0; pattern_mat = '0;
    repeat (3) tick();
    chk("reset outputs", {hsync, vsync, rgb, frame_tick} == 15'h6000,
        32'({hsync, vsync, rgb, frame_tick}), 32'h6000);
    rst = 1'b0;
    frame = 0;

    run_until(1, 0, 0);
    state = '0; draw = 1'b0;
    cursor_x = 8'd62; cursor_y = 8'd47;
    pattern_mat = 64'h201;

    run_until(2, 50, 0);
    state[47*GX+62] = 1'b1;
    state[0] = 1'b1;

    run_until(4, 0, 2);
    pix_ce = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall hold", {hsync, vsync, rgb} == last_px,
          32'({hsync, vsync, rgb}), 32'(last_px));
      chk("stall tick", frame_tick == 1'b0, 32'(frame_tick), 32'h0);
    end
    pix_ce = 1'b1;
    repeat (124) tick();
    chk("pre-reset pixel", rgb == 12'h004, 32'(rgb), 32'h004);

    rst = 1'b1;
    tick();
    chk("midframe reset", {hsync, vsync, rgb, frame_tick} == 15'h6000,
        32'({hsync, vsync, rgb, frame_tick}), 32'h6000);
    rst = 1'b0;
    frame = 100;
    repeat (2 * HT) tick();

    chk("hsync low count", hs_low == HS * VT, hs_low, HS * VT);
    chk("vsync low count", vs_low == VS * HT, vs_low, VS * HT);
    chk("frame_tick count", ft_cnt == 4, ft_cnt, 4);
    chk("probes reached", hits == pt.size(), hits, pt.size());

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/conway_vga_render.md
Name: conway_vga_render

Overview:
- Downstream consumer of the Life engine's `state` vector; scans it out as a 640x480@60 VGA raster.
- When the engine is in edit mode (draw=0), overlays the 8x8 brush pattern at the cursor.
- Snapshots state, cursor and pattern once per frame so the displayed frame never tears mid-generation.
- Emits a one-cycle frame_tick at vblank start, which the top level uses to pace generation steps.

Parameters:
- GRID_X, 64, cells per row (must equal the engine's MAX_X).
- GRID_Y, 48, cells per column (must equal the engine's MAX_Y).
- CELL_PX, 10, pixels per cell edge. GRID_X*CELL_PX <= H_VIS and GRID_Y*CELL_PX <= V_VIS.
- H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels.
- V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pix_ce  in  1  pixel clock enable (one pulse per pixel, e.g. every 2nd clk at 50 MHz).
- state  in  GRID_X*GRID_Y  cell vector; bit y*GRID_X+x is cell (x,y), 1 = alive.
- draw  in  1  0 = edit mode (overlay enabled), 1 = run mode.
- cursor_x  in  8  brush origin column.
- cursor_y  in  8  brush origin row.
- pattern_mat  in  64  brush; bit dy*8+dx maps to cell (cursor_x+dx, cursor_y+dy) with wrap-around.
- hsync  out  1  active-low horizontal sync.
- vsync  out  1  active-low vertical sync.
- rgb  out  12  4:4:4 colour, {R,G,B}.
- frame_tick  out  1  one-clk pulse at vblank start.

Behaviour:
- Reset (rst=1 at a clk edge): h_cnt=0, v_cnt=0, all sub-cell counters=0, shadow registers=0, hsync=1, vsync=1, rgb=0, frame_tick=0. Reset overrides pix_ce. Reset mid-frame restarts at pixel (0,0).
- Counters advance only on clk edges with pix_ce=1. Outputs hold when pix_ce=0.
- h_cnt runs 0..799 and wraps to 0. v_cnt increments when h_cnt wraps; v_cnt runs 0..524 and wraps to 0.
- Cell coordinates come from counters, with no divider. sub_x counts 0..CELL_PX-1 across the visible line, and cell_x increments when sub_x wraps. cell_x and sub_x reset at h_cnt=0. cell_y and sub_y follow the same scheme per visible line and reset at v_cnt=0.
- Sync (computed from the pre-register counters):
  - hsync=0 iff H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC.
  - vsync=0 iff V_VIS+V_FP <= v_cnt < V_VIS+V_FP+V_SYNC.
- Latency: hsync, vsync and rgb are all registered and delayed by exactly one pix_ce from the counter value that produced them, so the three stay mutually aligned.
- Snapshot: on the pix_ce cycle where h_cnt=0 and v_cnt=V_VIS, the block latches state, draw, cursor_x, cursor_y and pattern_mat into shadow registers. frame_tick=1 for that single clk only. The whole visible frame renders from the shadows.
- Colour, in priority order:
  - Blanking, i.e. h_cnt>=H_VIS or v_cnt>=V_VIS: 12'h000.
  - Outside the grid, i.e. cell_x>=GRID_X or cell_y>=GRID_Y: 12'h111.
  - Overlay active (shadow draw=0): compute ox=(cell_x-cursor_x) mod GRID_X and oy=(cell_y-cursor_y) mod GRID_Y.
    - In brush window (ox<8 and oy<8) with pattern bit oy*8+ox=1: 12'h0F0 if the cell is dead, 12'hFF0 if alive.
    - In brush window with pattern bit=0: 12'hFFF if alive, 12'h004 if dead.
  - Otherwise: alive 12'hFFF, dead 12'h000.
- Wrap rule: the brush window wraps across the right and bottom grid edges, identical to the engine's write mapping.
- Out-of-range cursor: if shadow cursor_x>=GRID_X or cursor_y>=GRID_Y, the overlay is suppressed for that frame.
- Input changes mid-frame have no visible effect until the next snapshot.

Test Plan:
- Reset/timing: rst for 3 clk, then pix_ce=1 every clk for 2 frames. Required per frame: exactly 800*525 pix_ce; hsync low for 96 pixels per line; vsync low for 2 lines; frame_tick exactly once per 420000 pix_ce.
- Single cell, draw=1: only bit 5*64+3 set. Required: rgb=12'hFFF exactly for pixels x=30..39, y=50..59 (counters, one-pix_ce output delay); 12'h000 elsewhere in the 640x480 visible area; no 12'h111 region since the grid covers the full screen.
- Overlay with wrap: draw=0, cursor=(62,47), pattern bit 0 and bit 9 set, state=0. Required: cell (62,47) shows 12'h0F0; cell (63,47) and cell (0,0) lie in the brush window with pattern bit 0, so show 12'h004; cell (63,0) (dx=1, dy=1) shows 12'h0F0.
- Alive under brush: same setup plus cell (62,47) alive. Required: that cell shows 12'hFF0.
- Snapshot: toggle state bit 0 at mid-frame line 200. Required: pixel (0,0) changes only in the frame after the next frame_tick.
- pix_ce stall: pix_ce held low 10 clk mid-line. Required: hsync/vsync/rgb and counters frozen. Then assert rst mid-frame: next outputs hsync=1, vsync=1, rgb=0, scan restarts at (0,0).
